// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the memory-bus stage.
package cpu_pkg;

  typedef enum logic [1:0] {BUS_IDLE, BUS_SETUP, BUS_ACCESS} bus_state_t;

  localparam int unsigned CPU_ADDR_W = 8;
  localparam int unsigned CPU_DATA_W = 8;

  // Read data returned when an access is aborted by the timeout.
  localparam logic [7:0] BUS_ERR_DATA = 8'hFF;

endpackage

// File: rtl/mem_wait_cnt.sv
// Saturating ACCESS-cycle counter with an optional mem_rdy-low timeout counter.
// The timeout counter exists only when MEM_BUS_TIMEOUT_EN is defined.
module mem_wait_cnt #(
  parameter int unsigned WAIT_N  = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_cycle,
  input  logic clr_i,
  input  logic rdy_i,
  output logic done_o,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(WAIT_N + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(WAIT_N)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_cycle) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of ACCESS cycles already finished, so the current
  // cycle is at or beyond WAIT_N once cnt_q reaches WAIT_N-1.
  assign done_o = (cnt_q >= CntW'(WAIT_N - 1));

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (clr_i) begin
      tmo_d = '0;
    end else if (done_o && !rdy_i && (tmo_q != TmoW'(TIMEOUT))) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_cycle) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign expired_o = done_o && (tmo_q >= TmoW'(TIMEOUT));
`else
  logic unused_rdy;
  assign unused_rdy = rdy_i ^ (TIMEOUT == 0);
  assign expired_o  = 1'b0;
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus stage: one request at a time, IDLE -> SETUP -> ACCESS with wait states.
// Optional access timeout is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = CPU_ADDR_W,
  parameter int unsigned DATA_W      = CPU_DATA_W,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              reset_cycle,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_ready,
  output logic              bus_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  localparam int unsigned WaitN = (WAIT_STATES == 0) ? 1 : WAIT_STATES;

  bus_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              oe_out_q, oe_out_d;
  logic              we_out_q, we_out_d;
  logic              bus_ready_q, bus_ready_d;
  logic              cnt_clr, cnt_done, cnt_expired;

`ifdef MEM_BUS_TIMEOUT_EN
  logic bus_err_q, bus_err_d;
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  mem_wait_cnt #(
    .WAIT_N (WaitN),
    .TIMEOUT(TIMEOUT)
  ) u_wait_cnt (
    .clk        (clk),
    .reset_cycle(reset_cycle),
    .clr_i      (cnt_clr),
    .rdy_i      (mem_rdy),
    .done_o     (cnt_done),
    .expired_o  (cnt_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    we_d        = we_q;
    oe_out_d    = oe_out_q;
    we_out_d    = we_out_q;
    bus_ready_d = bus_ready_q;
`ifdef MEM_BUS_TIMEOUT_EN
    bus_err_d   = bus_err_q;
`endif
    cnt_clr     = (state_q != BUS_ACCESS);

    unique case (state_q)
      BUS_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          we_d        = req_we;
          bus_ready_d = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
          bus_err_d   = 1'b0;
`endif
          state_d     = BUS_SETUP;
        end
      end
      BUS_SETUP: begin
        oe_out_d = !we_q;
        we_out_d = we_q;
        state_d  = BUS_ACCESS;
      end
      BUS_ACCESS: begin
        // A ready RAM on the expiry edge still completes normally.
        if (cnt_done && mem_rdy) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          bus_ready_d = 1'b1;
          oe_out_d    = 1'b0;
          we_out_d    = 1'b0;
          state_d     = BUS_IDLE;
        end else if (cnt_expired) begin
          if (!we_q) begin
            rdata_d = {DATA_W{1'b1}};
          end
          bus_ready_d = 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
          bus_err_d   = 1'b1;
`endif
          oe_out_d    = 1'b0;
          we_out_d    = 1'b0;
          state_d     = BUS_IDLE;
        end
      end
      default: begin
        state_d = BUS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_cycle) begin
      state_q     <= BUS_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      oe_out_q    <= 1'b0;
      we_out_q    <= 1'b0;
      bus_ready_q <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      oe_out_q    <= oe_out_d;
      we_out_q    <= we_out_d;
      bus_ready_q <= bus_ready_d;
`ifdef MEM_BUS_TIMEOUT_EN
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign req_ready = (state_q == BUS_IDLE);
  assign rdata     = rdata_q;
  assign bus_ready = bus_ready_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_oe    = oe_out_q;
  assign mem_we    = we_out_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a small RAM model; the timeout case
// runs only when MEM_BUS_TIMEOUT_EN is defined.
module tb_mem_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset_cycle;
  logic       req_valid;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic [7:0] rdata;
  logic       bus_ready;
  logic       bus_err;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_oe;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       mem_rdy;

  logic [7:0] ram [256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk        (clk),
    .reset_cycle(reset_cycle),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rdata      (rdata),
    .bus_ready  (bus_ready),
    .bus_err    (bus_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .mem_rdy    (mem_rdy)
  );

  always @(posedge clk) begin
    if (reset_cycle) begin
      ram[8'h10] <= 8'hA5;
      ram[8'h11] <= 8'h5A;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = ram[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // lat = index of the first falling edge (counted from the request being
  // presented to an idle block) at which bus_ready reads high.
  task automatic xfer(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                      input int rdy_at, output int lat, output int oe_n, output int we_n,
                      output int addr_bad, output logic err1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
    lat = -1; oe_n = 0; we_n = 0; addr_bad = 0; err1 = 1'bx;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        err1 = bus_err;
      end
      if (mem_oe) oe_n++;
      if (mem_we) begin
        we_n++;
        if (mem_addr != addr) addr_bad++;
      end
      if (bus_ready) lat = k;
      if (k == rdy_at) mem_rdy = 1'b1;
    end
  endtask

  initial begin
    int   lat, oe_n, we_n, addr_bad, busy_bad, acc_k;
    logic err1;

    reset_cycle = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = 8'h00;
    req_wdata   = 8'h00;
    mem_rdy     = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_bus_ready", bus_ready, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_oe_we", {mem_oe, mem_we}, 0);
    check_eq("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
    check_eq("rst_bus_err", bus_err, 0);
    reset_cycle = 1'b0;
    @(negedge clk);

    // Read 0x10 at default wait states.
    xfer(1'b0, 8'h10, 8'h00, 0, lat, oe_n, we_n, addr_bad, err1);
    check_eq("rd_latency", lat, 4);
    check_eq("rd_oe_cycles", oe_n, 2);
    check_eq("rd_we_cycles", we_n, 0);
    check_eq("rd_rdata", rdata, 8'hA5);
    check_eq("rd_bus_err", bus_err, 0);

    // Write 0x3C to 0x20, then read it back.
    xfer(1'b1, 8'h20, 8'h3C, 0, lat, oe_n, we_n, addr_bad, err1);
    check_eq("wr_latency", lat, 4);
    check_eq("wr_we_cycles", we_n, 2);
    check_eq("wr_oe_cycles", oe_n, 0);
    check_eq("wr_addr_bad", addr_bad, 0);
    check_eq("wr_rdata_kept", rdata, 8'hA5);
    check_eq("wr_bus_ready", bus_ready, 1);
    xfer(1'b0, 8'h20, 8'h00, 0, lat, oe_n, we_n, addr_bad, err1);
    check_eq("rdback_rdata", rdata, 8'h3C);
    check_eq("rdback_latency", lat, 4);

    // Stretch: mem_rdy low for ACCESS cycles 1..5, high from cycle 6.
    mem_rdy = 1'b0;
    xfer(1'b0, 8'h10, 8'h00, 7, lat, oe_n, we_n, addr_bad, err1);
    check_eq("str_latency", lat, 8);
    check_eq("str_oe_cycles", oe_n, 6);
    check_eq("str_rdata", rdata, 8'hA5);

    // Busy: req_valid held through a read, address switched to 0x11.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    req_addr = 8'h11;
    busy_bad = 0; acc_k = -1;
    for (int k = 2; k <= 40 && acc_k < 0; k++) begin
      @(negedge clk);
      if (bus_ready) acc_k = k;
      else if (req_ready) busy_bad++;
    end
    check_eq("busy_req_ready", busy_bad, 0);
    check_eq("busy_first_done", acc_k, 4);
    check_eq("busy_first_rdata", rdata, 8'hA5);
    check_eq("busy_ready_at_done", req_ready, 1);
    @(negedge clk);
    check_eq("busy_second_accept", {req_ready, bus_ready}, 2'b00);
    check_eq("busy_second_addr", mem_addr, 8'h11);
    req_valid = 1'b0;
    for (int w = 0; w < 40 && !bus_ready; w++) @(negedge clk);
    check_eq("busy_second_rdata", rdata, 8'h5A);

    // Reset held two cycles in the middle of ACCESS.
    mem_rdy = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_oe_before_rst", mem_oe, 1);
    reset_cycle = 1'b1;
    repeat (2) @(negedge clk);
    reset_cycle = 1'b0;
    check_eq("mid_rst_req_ready", req_ready, 1);
    check_eq("mid_rst_bus_ready", bus_ready, 0);
    check_eq("mid_rst_rdata", rdata, 0);
    check_eq("mid_rst_oe_we", {mem_oe, mem_we}, 0);
    mem_rdy = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_idle_next", {req_ready, bus_ready}, 2'b10);

`ifdef MEM_BUS_TIMEOUT_EN
    // mem_rdy stuck low: abort after 2 + 15 ACCESS cycles.
    mem_rdy = 1'b0;
    xfer(1'b0, 8'h10, 8'h00, 0, lat, oe_n, we_n, addr_bad, err1);
    check_eq("tmo_latency", lat, 19);
    check_eq("tmo_oe_cycles", oe_n, 17);
    check_eq("tmo_rdata", rdata, 8'hFF);
    check_eq("tmo_bus_err", bus_err, 1);
    mem_rdy = 1'b1;
    xfer(1'b0, 8'h10, 8'h00, 0, lat, oe_n, we_n, addr_bad, err1);
    check_eq("tmo_err_clr_accept", err1, 0);
    check_eq("tmo_after_rdata", rdata, 8'hA5);
    check_eq("tmo_after_bus_err", bus_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
